// File: rtl/pc_gen.sv
// pc_gen: fetch-group PC generator with redirect priority and stall-held redirects; PC_GEN_ALIGN_CHECK_EN adds addr_err.
module pc_gen #(
    parameter logic [31:0] PC_INITIAL  = 32'hbfc00000,
    parameter int          FETCH_WIDTH = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           debug_reset,
    input  logic                           is_debug,
    input  logic [31:0]                    debug_new_pc,
    input  logic                           is_exception,
    input  logic [31:0]                    exception_new_pc,
    input  logic                           is_branch,
    input  logic [31:0]                    branch_address,
    output logic [31:0]                    pc_reg,
    output logic [$clog2(FETCH_WIDTH):0]   fetch_slots,
    output logic                           redirect_pending,
    output logic                           addr_err
);
    localparam int          SB  = $clog2(FETCH_WIDTH);
    localparam logic [31:0] GRP = 32'(4 * FETCH_WIDTH);
    logic [31:0] r_pc;
    logic [1:0]  r_pend_cls;
    logic [31:0] r_pend_tgt;
    logic [1:0]  w_new_cls;
    logic [31:0] w_new_tgt;
    logic        w_take;
    logic [31:0] w_seq_pc;
    logic [31:0] w_next_pc;
    logic [SB:0] w_off;
    always_comb begin
        w_new_cls = is_debug ? 2'd3 : is_exception ? 2'd2 : is_branch ? 2'd1 : 2'd0;
        w_new_tgt = is_debug ? debug_new_pc : is_exception ? exception_new_pc : branch_address;
        w_take    = (w_new_cls != 2'd0) && (w_new_cls >= r_pend_cls);
        w_seq_pc  = (r_pc & ~(GRP - 32'd1)) + GRP;
        w_next_pc = w_take ? w_new_tgt : (r_pend_cls != 2'd0) ? r_pend_tgt : w_seq_pc;
        w_off     = (SB+1)'((r_pc >> 2) & 32'(FETCH_WIDTH - 1));
    end
    always_ff @(posedge clk) begin
        if (rst || debug_reset) begin
            r_pc       <= PC_INITIAL;
            r_pend_cls <= 2'd0;
        end else if (enable) begin
            r_pc       <= w_next_pc;
            r_pend_cls <= 2'd0;
        end else if (w_take) begin
            r_pend_cls <= w_new_cls;
            r_pend_tgt <= w_new_tgt;
        end
    end
`ifdef PC_GEN_ALIGN_CHECK_EN
    logic r_addr_err;
    always_ff @(posedge clk) begin
        if (rst || debug_reset) r_addr_err <= 1'b0;
        else if (enable) r_addr_err <= |w_next_pc[1:0];
    end
    assign addr_err = r_addr_err;
`else
    assign addr_err = 1'b0;
`endif
    assign pc_reg           = r_pc;
    assign fetch_slots      = (SB+1)'(FETCH_WIDTH) - w_off;
    assign redirect_pending = r_pend_cls != 2'd0;
endmodule
